// File: rtl/alu_result_serializer_pkg.sv
// alu_result_serializer_pkg: shared FSM state encoding and header constant
// for the ALU result serializer. Optional macro: ALU_TX_HEADER_EN.
package alu_result_serializer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
`ifdef ALU_TX_HEADER_EN
      ST_HDR  = 2'd1,
`endif
      ST_LO   = 2'd2,
      ST_HI   = 2'd3
   } state_e;

   localparam logic [7:0] HDR_BYTE = 8'hA5;

endpackage

// File: rtl/alu_result_serializer_fifo.sv
// result_fifo: power-of-two circular buffer holding pending ALU results.
// Ports: clk, rst (sync, active-high), push_i/din_i, pop_i/dout_o (head,
// show-ahead), full_o, empty_o. Push when full and pop when empty are ignored.
module result_fifo
   import alu_result_serializer_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [AW:0]      cnt_q;
   logic [AW:0]      cnt_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign dout_o  = mem_q[rd_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      cnt_d = cnt_q;
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= wr_q + AW'(1);
         end
         if (do_pop) begin
            rd_q <= rd_q + AW'(1);
         end
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_result_serializer.sv
// alu_result_serializer: buffers ALU results and sends each as bytes, low
// byte then high byte, over a valid/ready byte link. With ALU_TX_HEADER_EN
// defined, each result is preceded by header byte 8'hA5.
// Ports: clk, rst (sync, active-high), alu_out/alu_valid (result in),
// tx_data/tx_valid/tx_ready (byte out), busy, overflow (sticky drop flag).
module alu_result_serializer
   import alu_result_serializer_pkg::*;
#(
   parameter int OUT_WIDTH  = 16,
   parameter int BYTE_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [OUT_WIDTH-1:0]  alu_out,
   input  logic                  alu_valid,
   input  logic                  tx_ready,
   output logic [BYTE_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   output logic                  busy,
   output logic                  overflow
);

   state_e                  state_q;
   logic [OUT_WIDTH-1:0]    hold_q;
   logic [BYTE_WIDTH-1:0]   tx_data_q;
   logic                    tx_valid_q;
   logic                    overflow_q;

   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [OUT_WIDTH-1:0]    fifo_dout;

   state_e                  first_state;
   logic [BYTE_WIDTH-1:0]   first_data;

   assign fifo_push = alu_valid & ~fifo_full;

   // Pop when idle, or when the last byte of the current result is taken.
   assign fifo_pop = ~fifo_empty &
                     ((state_q == ST_IDLE) |
                      ((state_q == ST_HI) & tx_ready));

   // State and byte presented right after a result is loaded into hold.
`ifdef ALU_TX_HEADER_EN
   assign first_state = ST_HDR;
   assign first_data  = BYTE_WIDTH'(HDR_BYTE);
`else
   assign first_state = ST_LO;
   assign first_data  = fifo_dout[BYTE_WIDTH-1:0];
`endif

   result_fifo #(
      .WIDTH (OUT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .din_i   (alu_out),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         hold_q     <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         // Fullness is judged before this edge's pop.
         if (alu_valid && fifo_full) begin
            overflow_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  hold_q     <= fifo_dout;
                  state_q    <= first_state;
                  tx_data_q  <= first_data;
                  tx_valid_q <= 1'b1;
               end
            end
`ifdef ALU_TX_HEADER_EN
            ST_HDR: begin
               if (tx_ready) begin
                  state_q   <= ST_LO;
                  tx_data_q <= hold_q[BYTE_WIDTH-1:0];
               end
            end
`endif
            ST_LO: begin
               if (tx_ready) begin
                  state_q   <= ST_HI;
                  tx_data_q <= hold_q[OUT_WIDTH-1:BYTE_WIDTH];
               end
            end
            ST_HI: begin
               if (tx_ready) begin
                  if (!fifo_empty) begin
                     hold_q    <= fifo_dout;
                     state_q   <= first_state;
                     tx_data_q <= first_data;
                  end else begin
                     state_q    <= ST_IDLE;
                     tx_data_q  <= '0;
                     tx_valid_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               tx_data_q  <= '0;
               tx_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign overflow = overflow_q;
   assign busy     = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_alu_result_serializer.sv
// tb_alu_result_serializer: directed bench with a queue-based reference
// model of the serializer; honours ALU_TX_HEADER_EN.
module tb_alu_result_serializer;

   localparam int DEPTH = 4;
`ifdef ALU_TX_HEADER_EN
   localparam int BPR = 3;
`else
   localparam int BPR = 2;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] alu_out = '0;
   logic        alu_valid = 1'b0;
   logic        tx_ready = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        busy;
   logic        overflow;

   int n_cmp = 0;
   int n_err = 0;

   alu_result_serializer #(
      .OUT_WIDTH  (16),
      .BYTE_WIDTH (8),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_out   (alu_out),
      .alu_valid (alu_valid),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .busy      (busy),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: queue of pending results and the bytes of the result
   // currently being sent.
   logic [15:0] m_fifo[$];
   logic [7:0]  m_cur[$];
   bit          m_ovf = 0;
   bit          m_started = 0;

   always @(posedge clk) begin
      int          pre;
      bit          hs;
      logic [15:0] r;
      if (rst) begin
         m_fifo.delete();
         m_cur.delete();
         m_ovf = 0;
         m_started = 1;
      end else begin
         pre = m_fifo.size();
         hs  = (m_cur.size() > 0) && tx_ready;
         if (hs) void'(m_cur.pop_front());
         if (pre > 0 && m_cur.size() == 0) begin
            r = m_fifo.pop_front();
`ifdef ALU_TX_HEADER_EN
            m_cur.push_back(8'hA5);
`endif
            m_cur.push_back(r[7:0]);
            m_cur.push_back(r[15:8]);
         end
         if (alu_valid) begin
            if (pre == DEPTH) m_ovf = 1;
            else m_fifo.push_back(alu_out);
         end
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         chk("m_valid", 32'(tx_valid), 32'(m_cur.size() > 0));
         chk("m_data", 32'(tx_data),
             (m_cur.size() > 0) ? 32'(m_cur[0]) : 32'd0);
         chk("m_busy", 32'(busy),
             32'((m_cur.size() > 0) || (m_fifo.size() > 0)));
         chk("m_ovf", 32'(overflow), 32'(m_ovf));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Push one result with tx_ready=1 and check its bytes by cycle.
   task automatic run_single(input logic [15:0] v, input logic [7:0] lo,
                             input logic [7:0] hi);
      tx_ready  = 1'b1;
      alu_out   = v;
      alu_valid = 1'b1;
      cyc();
      alu_valid = 1'b0;
      cyc();
`ifdef ALU_TX_HEADER_EN
      @(negedge clk);
      chk("s_hdr_v", 32'(tx_valid), 32'd1);
      chk("s_hdr", 32'(tx_data), 32'hA5);
      cyc();
`endif
      @(negedge clk);
      chk("s_lo_v", 32'(tx_valid), 32'd1);
      chk("s_lo", 32'(tx_data), 32'(lo));
      cyc();
      @(negedge clk);
      chk("s_hi_v", 32'(tx_valid), 32'd1);
      chk("s_hi", 32'(tx_data), 32'(hi));
      cyc();
      @(negedge clk);
      chk("s_end_v", 32'(tx_valid), 32'd0);
      chk("s_end_busy", 32'(busy), 32'd0);
      cyc();
   endtask

   initial begin
      logic [7:0] first;
      int         cnt;
      int         run;
`ifdef ALU_TX_HEADER_EN
      first = 8'hA5;
`else
      first = 8'h34;
`endif
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", 32'(tx_valid), 32'd0);
      chk("rst_data", 32'(tx_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      cyc();

      run_single(16'h1234, 8'h34, 8'h12);

      // Backpressure on the first byte.
      tx_ready  = 1'b0;
      alu_out   = 16'h1234;
      alu_valid = 1'b1;
      cyc();
      alu_valid = 1'b0;
      cyc();
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", 32'(tx_valid), 32'd1);
         chk("bp_hold", 32'(tx_data), 32'(first));
         cyc();
      end
      tx_ready = 1'b1;
      @(negedge clk);
      chk("bp_rel", 32'(tx_data), 32'(first));
      cyc();
`ifdef ALU_TX_HEADER_EN
      @(negedge clk);
      chk("bp_lo", 32'(tx_data), 32'h34);
      cyc();
`endif
      @(negedge clk);
      chk("bp_next", 32'(tx_data), 32'h12);
      cyc();
      cyc();

      // Overflow: six results while stalled, sixth is dropped.
      tx_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         alu_out   = 16'h1100 * 16'(k + 1) + 16'(k);
         alu_valid = 1'b1;
         cyc();
      end
      alu_valid = 1'b0;
      @(negedge clk);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_busy", 32'(busy), 32'd1);
      cyc();
      tx_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx_valid && tx_ready) cnt++;
         cyc();
      end
      chk("ovf_bytes", 32'(cnt), 32'(5 * BPR));
      @(negedge clk);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      cyc();

      // Back-to-back: two results, no idle gap.
      tx_ready = 1'b0;
      alu_out = 16'h5566;
      alu_valid = 1'b1;
      cyc();
      alu_out = 16'h7788;
      cyc();
      alu_valid = 1'b0;
      cyc();
      tx_ready = 1'b1;
      run = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx_valid) run++;
         else if (run > 0) break;
         cyc();
      end
      chk("b2b_run", 32'(run), 32'(2 * BPR));
      cyc();

      // Reset while sending the high byte with two results queued.
      tx_ready = 1'b0;
      alu_out = 16'hC3D4;
      alu_valid = 1'b1;
      cyc();
      alu_out = 16'h0102;
      cyc();
      alu_out = 16'h0304;
      cyc();
      alu_valid = 1'b0;
      cyc();
      tx_ready = 1'b1;
      repeat (BPR - 1) cyc();
      tx_ready = 1'b0;
      @(negedge clk);
      chk("mr_hi", 32'(tx_data), 32'hC3);
      chk("mr_busy_pre", 32'(busy), 32'd1);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      tx_ready = 1'b1;
      @(negedge clk);
      chk("mr_valid", 32'(tx_valid), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_ovf", 32'(overflow), 32'd0);
      cyc();
      repeat (6) begin
         @(negedge clk);
         chk("mr_quiet", 32'(tx_valid), 32'd0);
         cyc();
      end

      run_single(16'hBEEF, 8'hEF, 8'hBE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_result_serializer.md
ALU_RESULT_SERIALIZER -- requirements
Module: alu_result_serializer

Interface
REQ-001 Parameter OUT_WIDTH, default 16: width of the ALU result word; SHALL equal 2*BYTE_WIDTH.
REQ-002 Parameter BYTE_WIDTH, default 8: width of one transmitted byte.
REQ-003 Parameter FIFO_DEPTH, default 4: result-buffer entries; SHALL be a power of two, minimum 2.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 alu_out  input  OUT_WIDTH  ALU result word.
REQ-007 alu_valid  input  1  alu_out is a new result this cycle; each high cycle is one distinct result.
REQ-008 tx_ready  input  1  downstream UART transmitter accepts a byte this cycle.
REQ-009 tx_data  output  BYTE_WIDTH  byte offered to the transmitter.
REQ-010 tx_valid  output  1  tx_data is valid; transfer occurs when tx_valid && tx_ready.
REQ-011 busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.
REQ-012 overflow  output  1  sticky flag: at least one result was dropped.

Function
REQ-013 The block SHALL push alu_out into the FIFO on every rising edge where alu_valid=1 and the FIFO is not full.
REQ-014 Fullness for push SHALL be judged on the pre-edge count; alu_valid while full SHALL drop the result and set overflow, even if a pop occurs on the same edge.
REQ-015 FSM states: IDLE, HDR (only when ALU_TX_HEADER_EN is defined), LO, HI.
REQ-016 IDLE: if FIFO non-empty, pop the head into the holding register and go to HDR (macro defined) or LO; otherwise stay in IDLE.
REQ-017 HDR: tx_valid=1, tx_data=8'hA5; on tx_ready go to LO.
REQ-018 LO: tx_valid=1, tx_data=hold[BYTE_WIDTH-1:0]; on tx_ready go to HI.
REQ-019 HI: tx_valid=1, tx_data=hold[OUT_WIDTH-1:BYTE_WIDTH]; on tx_ready, if the FIFO is non-empty pop it and go to HDR/LO (back-to-back, no IDLE cycle); otherwise go to IDLE.
REQ-020 While tx_valid=1 and tx_ready=0, tx_data and the state SHALL hold unchanged.
REQ-021 In IDLE, tx_valid SHALL be 0 and tx_data SHALL be 0.
REQ-022 Latency: alu_valid=1 into an empty FIFO with FSM IDLE in cycle N -> first byte has tx_valid=1 in cycle N+2.
REQ-023 A simultaneous push and pop SHALL leave the count unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 Byte order SHALL be low byte first, then high byte.

Reset
REQ-025 With rst=1 at a rising edge: FSM=IDLE, FIFO count and pointers=0, hold=0, tx_valid=0, tx_data=0, busy=0, overflow=0.
REQ-026 Reset mid-transfer SHALL abandon the current result and discard all FIFO contents; no partial byte is emitted after reset.
REQ-027 overflow SHALL clear only on reset.

Configuration
REQ-028 Macro ALU_TX_HEADER_EN: when defined, each result SHALL be sent as three bytes, 8'hA5, LO, HI; when undefined, the HDR state SHALL not exist and each result SHALL be two bytes, LO, HI.

Structure
REQ-029 A shared package SHALL hold the FSM state enumeration and the header constant 8'hA5.
REQ-030 The FIFO SHALL be a sub-module named result_fifo, with push/pop/full/empty ports, instantiated once.

Verification
REQ-031 Single result, macro off: alu_out=16'h1234, alu_valid for 1 cycle, tx_ready=1 -> tx_data 8'h34 in N+2, then 8'h12 in N+3, then tx_valid=0.
REQ-032 Backpressure: tx_ready=0 for 5 cycles during LO -> tx_data stays 8'h34 with tx_valid=1; after tx_ready rises, the next byte is 8'h12.
REQ-033 Overflow: tx_ready=0, alu_valid for 6 consecutive cycles with distinct values -> 1 result in hold plus 4 in the FIFO; the 6th is dropped and overflow=1; then tx_ready=1 -> exactly 5 results (10 bytes) appear, in order.
REQ-034 Back-to-back: two results queued, tx_ready=1 -> 4 consecutive valid bytes with no idle cycle between the HI byte and the next LO byte.
REQ-035 Reset mid-operation: rst asserted while in HI with 2 results queued -> next cycle tx_valid=0, busy=0, overflow=0, and no further bytes until new alu_valid.
REQ-036 Macro on: alu_out=16'hBEEF -> bytes 8'hA5, 8'hEF, 8'hBE in order.
